tap_playback_ctrl: RTL
======================

// Module: tap_playback_ctrl
// PURPOSE
//  Sequences cassette TAP playback. Walks a TAP image in byte memory: skips the 20-byte header,
//  feeds sample bytes to sample_assembler over data_valid/ack, and takes back timer_val/load_timer.
//  Turns those periods into the square-wave pwm drive that sample_assembler and the C64 cassette
//  read line both consume. Sits between the SD/DDR image reader and sample_assembler.
//  Owns play/stop/rewind, motor gating and end-of-file handling.
// PARAMETERS
//  HDR_LEN    20  header bytes skipped; the first sample byte is at address HDR_LEN
//  ADDR_W     24  memory address / file length width
//  PERIOD_W   24  timer_val width (matches sample_assembler)
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous active-low reset
//  tick         in   1        phi2 clock enable (~985 kHz); the pulse timer advances only on tick
//  play         in   1        level; rising edge starts or resumes playback
//  stop         in   1        level; pauses playback; the address is retained
//  rewind       in   1        1-cycle pulse; address <= 0; accepted only in IDLE/DONE/ERROR
//  motor        in   1        cassette motor line; the pulse timer freezes while 0
//  file_len     in   ADDR_W   image length in bytes
//  mem_addr     out  ADDR_W   byte address to the image reader
//  mem_rd       out  1        read request; held until mem_valid
//  mem_data     in   8        read data
//  mem_valid    in   1        mem_data valid; 1-cycle pulse
//  data         out  8        sample byte to sample_assembler
//  data_valid   out  1        data offered; held until ack
//  ack          in   1        byte consumed this cycle when data_valid & ack
//  restart      out  1        1-cycle pulse to sample_assembler
//  timer_val    in   PERIOD_W next pulse period, in ticks
//  load_timer   in   1        capture timer_val
//  pwm          out  1        pulse wave: high for the first half of the period, low for the second
//  sense_n      out  1        cassette sense; 0 whenever not IDLE
//  eof          out  1        1 in DONE
//  underrun     out  1        sticky; cleared by play rising edge
// BEHAVIOUR
//  Reset values: mem_addr=0, mem_rd=0, data=0, data_valid=0, restart=0, pwm=1, sense_n=1,
//   eof=0, underrun=0, state=IDLE, pending_valid=0, count=0.
//  FSM, byte side:
//   IDLE: on play rise, if addr==0 -> HEADER, else -> FETCH. restart pulses on entry to HEADER.
//   HEADER: read addr 0..HDR_LEN-1; each mem_valid increments addr; at addr==HDR_LEN -> FETCH.
//   FETCH: if addr>=file_len -> DONE; else mem_rd=1 -> WAIT_MEM.
//   WAIT_MEM: on mem_valid, latch data, addr++, data_valid=1 -> OFFER.
//   OFFER: hold data/data_valid until ack, then -> FETCH. One byte buffered; no prefetch.
//   DONE: eof=1; pwm held high. play rise with addr<file_len -> FETCH; rewind -> IDLE.
//  Stop (any state): mem_rd completes if already issued (the byte is latched, not offered)
//   -> IDLE; data_valid drops; timer frozen; resume continues at the same addr.
//  play and stop asserted together: stop wins.
//  Pulse timer, on tick & motor & state!=IDLE:
//   load_timer: pending <= timer_val, pending_valid <= 1. Same-cycle load and reload: pending wins.
//   count==0 & pending_valid: count <= pending; half <= pending>>1; pwm <= 1; pending_valid <= 0.
//   count==0 & !pending_valid & state!=DONE: pwm stays 1; underrun <= 1; retried every tick.
//   otherwise: count--; pwm <= (count > half).
//  Arithmetic: a period of 0 is treated as 1. count is PERIOD_W wide and never wraps.
//  The falling pwm edge mid-period lets sample_assembler fetch the next sample before count hits 0.
//  reset_n low mid-operation: everything returns to reset values immediately; the address is lost.
// CONFIGURATION
//  TAP_HEADER_CHECK_EN defined:
//   - HEADER compares bytes 0..11 with "C64-TAPE-RAW".
//   - Byte 12 (version) must be 0 or 1.
//   - On mismatch -> ERROR: output err=1; only rewind or reset exits.
//  Not defined: header bytes are discarded unchecked; err is tied 0; there is no ERROR state.
// STRUCTURE
//  tap_pkg: state enum encodings, HDR_LEN default, the 12-byte signature constant.
//  Sub-module tap_pulse_timer: tick/motor gating, the pending register, count/half, pwm, underrun.
//  The top level holds the FSM, address counter and byte handshake.
// TESTING
//  1. file_len=22; bytes 20,21 = 0x30,0x40; play -> restart 1 cycle.
//     Addr 0..19 read unoffered; data 0x30 then 0x40 offered; then DONE, eof=1.
//  2. Period check: timer_val=0x180 on load_timer, motor=1.
//     pwm high 0xC0 ticks, low 0xC0 ticks; count frozen while tick=0.
//  3. Motor drop mid-period at count=0x50: pwm and count hold.
//     Motor back: period completes with total high+low = 0x180 ticks.
//  4. Stop while in OFFER at addr 25 -> data_valid=0, IDLE, sense_n=1.
//     Play -> FETCH reads addr 25; no restart pulse.
//  5. Withhold load_timer past count==0 -> pwm stays 1, underrun=1; the next load resumes pulses.
//  6. TAP_HEADER_CHECK_EN with byte 3 = 'X' -> err=1, no data_valid.
//     Rewind -> IDLE, addr 0.
//     Without the macro, the same image plays normally.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared types and constants for the TAP playback controller.
// TAP_HEADER_CHECK_EN adds the ERROR state used by the header validator.
package tap_pkg;

  localparam int HDR_LEN_DEF = 20;
  localparam int SIG_LEN     = 12;
  localparam logic [8*SIG_LEN-1:0] TAP_SIG = "C64-TAPE-RAW";

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEADER   = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WAIT_MEM = 3'd3,
    ST_OFFER    = 3'd4,
    ST_DONE     = 3'd5
`ifdef TAP_HEADER_CHECK_EN
    , ST_ERROR  = 3'd6
`endif
  } tap_state_e;

  // Byte idx of the signature, counted from the first character.
  function automatic logic [7:0] sig_byte(input int idx);
    return TAP_SIG[8*(SIG_LEN-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/tap_pulse_timer.sv
// Converts loaded pulse periods into the pwm square wave; advances only on
// tick while the motor runs and playback is active.
module tap_pulse_timer
  import tap_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                motor,
  input  logic                active,
  input  logic                done,
  input  logic                clr_underrun,
  input  logic                load_timer,
  input  logic [PERIOD_W-1:0] timer_val,
  output logic                pwm,
  output logic                underrun
);

  logic [PERIOD_W-1:0] pending_q;
  logic                pending_valid_q;
  logic [PERIOD_W-1:0] count_q;
  logic [PERIOD_W-1:0] half_q;
  logic                pwm_q;
  logic                underrun_q;
  logic [PERIOD_W-1:0] period_eff;
  logic                step;

  assign step       = tick & motor & active;
  assign period_eff = (pending_q == '0) ? PERIOD_W'(1) : pending_q;

  // count runs period-1 .. 0, so the reload tick itself is part of the period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      count_q         <= '0;
      half_q          <= '0;
      pwm_q           <= 1'b1;
      underrun_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every branch below read pre-edge values.
      if (clr_underrun) underrun_q <= 1'b0;
      if (step) begin
        if (load_timer) begin
          pending_q       <= timer_val;
          pending_valid_q <= 1'b1;
        end
        if (count_q == '0) begin
          pwm_q <= 1'b1;
          if (pending_valid_q) begin
            count_q <= period_eff - PERIOD_W'(1);
            half_q  <= period_eff >> 1;
            if (!load_timer) pending_valid_q <= 1'b0;
          end else if (!done) begin
            underrun_q <= 1'b1;
          end
        end else begin
          count_q <= count_q - PERIOD_W'(1);
          pwm_q   <= (count_q > half_q);
        end
      end
      if (done) pwm_q <= 1'b1;
    end
  end

  assign pwm      = pwm_q;
  assign underrun = underrun_q;

endmodule

// File: rtl/tap_playback_ctrl.sv
// TAP image playback sequencer: header skip, byte handshake, transport control.
// Define TAP_HEADER_CHECK_EN to validate the signature/version and flag err.
module tap_playback_ctrl
  import tap_pkg::*;
#(
  parameter int HDR_LEN  = HDR_LEN_DEF,
  parameter int ADDR_W   = 24,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                play,
  input  logic                stop,
  input  logic                rewind,
  input  logic                motor,
  input  logic [ADDR_W-1:0]   file_len,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_data,
  input  logic                mem_valid,
  output logic [7:0]          data,
  output logic                data_valid,
  input  logic                ack,
  output logic                restart,
  input  logic [PERIOD_W-1:0] timer_val,
  input  logic                load_timer,
  output logic                pwm,
  output logic                sense_n,
  output logic                eof,
  output logic                underrun,
  output logic                err
);

  tap_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              mem_rd_q;
  logic              data_valid_q;
  logic              restart_q;
  logic              sense_n_q;
  logic              eof_q;
  logic              play_q;
  logic              play_rise;
  logic              stop_hit;
  logic              timer_active;
  logic              timer_done;

  assign play_rise    = play & ~play_q;
  assign timer_active = (state_q != ST_IDLE);
  assign timer_done   = (state_q == ST_DONE);

`ifdef TAP_HEADER_CHECK_EN
  logic err_q;
  logic hdr_bad;

  assign stop_hit = stop && (state_q != ST_IDLE) && (state_q != ST_ERROR);

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    hdr_bad = 1'b0;
    if (addr_q < ADDR_W'(SIG_LEN))
      hdr_bad = (mem_data != sig_byte(int'(addr_q[3:0])));
    else if (addr_q == ADDR_W'(SIG_LEN))
      hdr_bad = (mem_data > 8'd1);
  end

  assign err = err_q;
`else
  assign stop_hit = stop && (state_q != ST_IDLE);
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      mem_rd_q     <= 1'b0;
      data_valid_q <= 1'b0;
      restart_q    <= 1'b0;
      sense_n_q    <= 1'b1;
      eof_q        <= 1'b0;
      play_q       <= 1'b0;
`ifdef TAP_HEADER_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      play_q    <= play;
      restart_q <= 1'b0;
      if (stop_hit) begin
        // An outstanding read still completes, from IDLE, without advancing addr.
        state_q      <= ST_IDLE;
        sense_n_q    <= 1'b1;
        eof_q        <= 1'b0;
        data_valid_q <= 1'b0;
        if (mem_rd_q && mem_valid) begin
          mem_rd_q <= 1'b0;
          data_q   <= mem_data;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (mem_rd_q) begin
              if (mem_valid) begin
                mem_rd_q <= 1'b0;
                data_q   <= mem_data;
              end
            end else if (play_rise && !stop) begin
              sense_n_q <= 1'b0;
              if (addr_q == '0) begin
                state_q   <= ST_HEADER;
                restart_q <= 1'b1;
              end else if (addr_q < ADDR_W'(HDR_LEN)) begin
                state_q <= ST_HEADER;
              end else begin
                state_q <= ST_FETCH;
              end
            end else if (rewind) begin
              addr_q <= '0;
            end
          end
          ST_HEADER: begin
            if (!mem_rd_q) begin
              if (addr_q == ADDR_W'(HDR_LEN)) state_q  <= ST_FETCH;
              else                            mem_rd_q <= 1'b1;
            end else if (mem_valid) begin
              mem_rd_q <= 1'b0;
              addr_q   <= addr_q + 1'b1;
`ifdef TAP_HEADER_CHECK_EN
              if (hdr_bad) begin
                state_q <= ST_ERROR;
                err_q   <= 1'b1;
              end
`endif
            end
          end
          ST_FETCH: begin
            if (addr_q >= file_len) begin
              state_q <= ST_DONE;
              eof_q   <= 1'b1;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= ST_WAIT_MEM;
            end
          end
          ST_WAIT_MEM: begin
            if (mem_valid) begin
              mem_rd_q     <= 1'b0;
              data_q       <= mem_data;
              addr_q       <= addr_q + 1'b1;
              data_valid_q <= 1'b1;
              state_q      <= ST_OFFER;
            end
          end
          ST_OFFER: begin
            if (ack) begin
              data_valid_q <= 1'b0;
              state_q      <= ST_FETCH;
            end
          end
          ST_DONE: begin
            if (play_rise && !stop && (addr_q < file_len)) begin
              state_q <= ST_FETCH;
              eof_q   <= 1'b0;
            end else if (rewind) begin
              state_q   <= ST_IDLE;
              addr_q    <= '0;
              eof_q     <= 1'b0;
              sense_n_q <= 1'b1;
            end
          end
`ifdef TAP_HEADER_CHECK_EN
          ST_ERROR: begin
            if (rewind) begin
              state_q   <= ST_IDLE;
              addr_q    <= '0;
              err_q     <= 1'b0;
              sense_n_q <= 1'b1;
            end
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_addr   = addr_q;
  assign mem_rd     = mem_rd_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign restart    = restart_q;
  assign sense_n    = sense_n_q;
  assign eof        = eof_q;

  tap_pulse_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .motor        (motor),
    .active       (timer_active),
    .done         (timer_done),
    .clr_underrun (play_rise),
    .load_timer   (load_timer),
    .timer_val    (timer_val),
    .pwm          (pwm),
    .underrun     (underrun)
  );

endmodule
